// File: rtl/s2p_collect.sv
// Serial-to-parallel collector: assembles WIDTH-bit LSB-first frames into a held
// parallel word with valid/ready handoff and a sticky overrun flag.
// Optional: define S2P_COLLECT_DROP_CNT_EN to add an 8-bit saturating drop counter.
module s2p_collect #(
    parameter int WIDTH = 8
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic             sof,
    input  logic             y_in,
    output logic [WIDTH-1:0] word,
    output logic             valid,
    input  logic             ready,
    output logic             ovr,
    output logic             busy
`ifdef S2P_COLLECT_DROP_CNT_EN
    ,
    output logic [7:0]       drop_cnt
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] sr_reg;
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] word_reg;
    logic             valid_reg;
    logic             ovr_reg;
    logic             busy_reg;
    logic             complete;
    logic             load_ok;

    // New bits enter at the MSB; after WIDTH shifts the first bit sits in bit 0.
    assign sr_next  = {y_in, sr_reg[WIDTH-1:1]};
    // A sof in the would-be completion cycle starts a new frame instead.
    assign complete = (state_reg == SHIFT) && !sof && (cnt_reg == LAST_CNT);
    assign load_ok  = !valid_reg || ready;

    always_ff @(posedge t_clk) begin
        if (r) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            sr_reg    <= '0;
            word_reg  <= '0;
            valid_reg <= 1'b0;
            ovr_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            if (sof) begin
                sr_reg    <= {y_in, {(WIDTH-1){1'b0}}};
                cnt_reg   <= CW'(1);
                state_reg <= SHIFT;
                busy_reg  <= 1'b1;
            end else if (state_reg == SHIFT) begin
                if (complete) begin
                    sr_reg    <= '0;
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end else begin
                    sr_reg  <= sr_next;
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            if (complete) begin
                if (load_ok) begin
                    word_reg  <= sr_next;
                    valid_reg <= 1'b1;
                end else begin
                    ovr_reg <= 1'b1;
                end
            end else if (valid_reg && ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign word  = word_reg;
    assign valid = valid_reg;
    assign ovr   = ovr_reg;
    assign busy  = busy_reg;

`ifdef S2P_COLLECT_DROP_CNT_EN
    logic [7:0] drop_cnt_reg;

    always_ff @(posedge t_clk) begin
        if (r) begin
            drop_cnt_reg <= 8'd0;
        end else if (complete && !load_ok && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: doc/s2p_collect.md
S2P_COLLECT -- requirements
Module: s2p_collect

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of serial bits per word (range 2..32).
REQ-002 SHALL have port t_clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 SHALL have port r, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port sof, input, 1 bit: start of frame, high in the cycle that carries the LSB.
REQ-005 SHALL have port y_in, input, 1 bit: serial data from the upstream two's-complement stage, LSB first.
REQ-006 SHALL have port word, output, WIDTH bits: the assembled parallel word.
REQ-007 SHALL have port valid, output, 1 bit: word holds an unconsumed word.
REQ-008 SHALL have port ready, input, 1 bit: consumer accepts word when valid && ready.
REQ-009 SHALL have port ovr, output, 1 bit: sticky overrun flag.
REQ-010 SHALL have port busy, output, 1 bit: a frame is being collected.

Function
REQ-011 SHALL use two collection states: IDLE and SHIFT.
REQ-012 In IDLE with sof=0, SHALL ignore y_in.
REQ-013 In IDLE with sof=1, SHALL capture y_in as bit 0, set the bit count to 1 and enter SHIFT.
REQ-014 In SHIFT, SHALL right-shift each cycle with the new bit inserted at the MSB side, so that bit k of the frame lands in word[k].
REQ-015 SHALL treat the cycle in which the WIDTH-th bit is sampled as completion: load word, assert valid on the next edge, return to IDLE.
REQ-016 SHALL have a latency of 1 cycle from the last bit sample to valid=1; there is no gap requirement between frames.
REQ-017 sof=1 while in SHIFT SHALL abort the partial frame (discarded, no flag) and restart it with the current bit as bit 0.
REQ-018 SHALL accept sof=1 in the completion cycle as a new frame start; that cycle's bit is then the new frame's bit 0, not the old frame's last bit.
REQ-019 valid SHALL clear on the edge where valid && ready, unless a new word completes in the same cycle.
REQ-020 When a word completes while valid=1 and ready=0, SHALL keep the old word, drop the new one and set ovr.
REQ-021 When a word completes in the same cycle as valid && ready, SHALL load the new word, keep valid=1 and leave ovr unchanged.
REQ-022 ovr SHALL clear only on r.
REQ-023 word SHALL remain stable while valid=1 and not consumed.
REQ-024 busy SHALL equal 1 exactly while in SHIFT.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL never wrap past WIDTH.

Reset
REQ-026 r=1 SHALL force IDLE, count=0, shift register=0, word=0, valid=0, ovr=0 and busy=0 on the next edge.
REQ-027 r SHALL override sof, ready and frame completion.
REQ-028 r mid-frame SHALL discard the partial frame.
REQ-029 The first frame after reset SHALL be accepted at the earliest in the cycle after r falls.

Configuration
REQ-030 Macro S2P_COLLECT_DROP_CNT_EN, when defined, SHALL add output drop_cnt, 8 bits, counting dropped words (REQ-020).
REQ-031 drop_cnt SHALL saturate at 255 and reset to 0.
REQ-032 When S2P_COLLECT_DROP_CNT_EN is undefined, there SHALL be no drop_cnt port and no counter logic, and all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-033 After reset, sof=1 with bits 1,0,1,1,0,1,0,0 and ready=1 -> valid=1 for 1 cycle, 1 cycle after the last bit, with word=8'h2D, ovr=0.
REQ-034 Two back-to-back frames 8'h2D then 8'hF3 with ready=0 -> word stays 8'h2D, valid=1, ovr=1, drop_cnt=1 (macro defined).
REQ-035 With valid=1 holding 8'h2D, pulse ready exactly in the completion cycle of 8'h80 -> word=8'h80, valid stays 1, ovr=0.
REQ-036 sof after 3 bits, then full frame 8'h01 -> word=8'h01; the aborted partial frame never appears; ovr=0.
REQ-037 Assert r after 5 bits of a frame -> all outputs 0 the next cycle; bits following without sof produce no valid.
REQ-038 Feed 300 dropped frames with the macro defined -> drop_cnt=255; r -> drop_cnt=0.
